// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer.
//   pc_mode_t       : 3-bit next-PC mode select (codes 6 and 7 reserved, act as SEQ)
//   PC_XLEN_DEFAULT : default PC / address width
package pc_seq_pkg;

  localparam int unsigned PC_XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    PCM_SEQ    = 3'd0,
    PCM_BRANCH = 3'd1,
    PCM_JUMP   = 3'd2,
    PCM_JREG   = 3'd3,
    PCM_CALL   = 3'd4,
    PCM_RET    = 3'd5
  } pc_mode_t;

endpackage

// File: rtl/pc_sequencer_ras.sv
// Return-address stack: circular buffer with a write pointer and valid count.
//   clk, Reset : clock, synchronous active-high reset
//   push, pop  : stack operations (caller guarantees at most one per cycle)
//   din        : address to push
//   top        : most recently pushed entry (valid while count != 0)
//   count      : number of valid entries, 0..DEPTH
//   ovf, unf   : one-cycle pulses for push-when-full / pop-when-empty
module ras_stack #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [XLEN-1:0]          din,
  output logic [XLEN-1:0]          top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic                     unf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic             full;
  logic             empty;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  // ptr is the next free slot; when full it also marks the oldest entry,
  // so a push on a full stack overwrites the oldest address naturally.
  assign top   = mem[ptr - PTR_W'(1)];

  always_ff @(posedge clk) begin
    if (Reset) begin
      ptr   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      ovf <= 1'b0;
      unf <= 1'b0;
      if (push) begin
        ptr <= ptr + PTR_W'(1);
        if (full) ovf   <= 1'b1;
        else      count <= count + CNT_W'(1);
      end else if (pop) begin
        if (empty) begin
          unf <= 1'b1;
        end else begin
          ptr   <= ptr - PTR_W'(1);
          count <= count - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !Reset) mem[ptr] <= din;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with next-PC mode mux and return-address stack.
//   clk, Reset   : clock, synchronous active-high reset (dominates everything)
//   ready_i      : fetch accepts pc_o; all state advances only when high
//   mode_i       : next-PC mode (pc_mode_t)
//   taken_i      : branch taken (BRANCH only)
//   boff_i       : signed byte offset relative to pc_plus4_o
//   jidx_i       : word index for JUMP / CALL
//   jreg_i       : register target for JREG
//   pc_o         : current PC
//   pc_plus4_o   : pc_o + 4
//   ras_count_o  : valid RAS entries
//   ras_ovf_o, ras_unf_o, misalign_o : one-cycle event pulses
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     XLEN         = PC_XLEN_DEFAULT,
  parameter int unsigned     JIDX_W       = 26,
  parameter int unsigned     RAS_DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic                         clk,
  input  logic                         Reset,
  input  logic                         ready_i,
  input  logic [2:0]                   mode_i,
  input  logic                         taken_i,
  input  logic [XLEN-1:0]              boff_i,
  input  logic [JIDX_W-1:0]            jidx_i,
  input  logic [XLEN-1:0]              jreg_i,
  output logic [XLEN-1:0]              pc_o,
  output logic [XLEN-1:0]              pc_plus4_o,
  output logic [$clog2(RAS_DEPTH):0]   ras_count_o,
  output logic                         ras_ovf_o,
  output logic                         ras_unf_o,
  output logic                         misalign_o
);

  logic            advance;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] jump_tgt;
  logic [XLEN-1:0] ras_top;
  logic            ras_push;
  logic            ras_pop;

  assign advance    = ready_i & ~Reset;
  assign pc_plus4_o = pc_o + XLEN'(4);

  // Wide indices leave no upper PC field; keep only the bits that fit.
  generate
    if (JIDX_W + 2 < XLEN) begin : g_jump_region
      assign jump_tgt = {pc_plus4_o[XLEN-1:JIDX_W+2], jidx_i, 2'b00};
    end else begin : g_jump_full
      assign jump_tgt = {jidx_i[XLEN-3:0], 2'b00};
    end
  endgenerate

  always_comb begin
    next_pc  = pc_plus4_o;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    case (mode_i)
      PCM_BRANCH: if (taken_i) next_pc = pc_plus4_o + boff_i;
      PCM_JUMP:   next_pc = jump_tgt;
      PCM_JREG:   next_pc = {jreg_i[XLEN-1:2], 2'b00};
      PCM_CALL: begin
        next_pc  = jump_tgt;
        ras_push = advance;
      end
      PCM_RET: begin
        ras_pop = advance;
        if (ras_count_o != '0) next_pc = ras_top;
      end
      default: next_pc = pc_plus4_o;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      pc_o       <= RESET_VECTOR;
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= ready_i && (mode_i == PCM_JREG) && (jreg_i[1:0] != 2'b00);
      if (ready_i) pc_o <= next_pc;
    end
  end

  ras_stack #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .Reset (Reset),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc_plus4_o),
    .top   (ras_top),
    .count (ras_count_o),
    .ovf   (ras_ovf_o),
    .unf   (ras_unf_o)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (RESET_VECTOR = 0x100, RAS_DEPTH = 4).
module tb_pc_sequencer;

  localparam logic [2:0] M_SEQ = 3'd0, M_BR = 3'd1, M_JMP = 3'd2,
                         M_JREG = 3'd3, M_CALL = 3'd4, M_RET = 3'd5;

  logic        clk;
  logic        Reset;
  logic        ready_i;
  logic [2:0]  mode_i;
  logic        taken_i;
  logic [31:0] boff_i;
  logic [25:0] jidx_i;
  logic [31:0] jreg_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [2:0]  ras_count_o;
  logic        ras_ovf_o;
  logic        ras_unf_o;
  logic        misalign_o;

  int errors = 0;
  int checks = 0;

  pc_sequencer #(
    .XLEN         (32),
    .JIDX_W       (26),
    .RAS_DEPTH    (4),
    .RESET_VECTOR (32'h0000_0100)
  ) dut (
    .clk         (clk),
    .Reset       (Reset),
    .ready_i     (ready_i),
    .mode_i      (mode_i),
    .taken_i     (taken_i),
    .boff_i      (boff_i),
    .jidx_i      (jidx_i),
    .jreg_i      (jreg_i),
    .pc_o        (pc_o),
    .pc_plus4_o  (pc_plus4_o),
    .ras_count_o (ras_count_o),
    .ras_ovf_o   (ras_ovf_o),
    .ras_unf_o   (ras_unf_o),
    .misalign_o  (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full registered-state check: pc, count and the three pulses.
  task automatic expect_state(input string tag, input logic [31:0] pc, input logic [2:0] cnt,
                              input logic ovf, input logic unf, input logic mis);
    chk({tag, ".pc"},    pc_o,        pc);
    chk({tag, ".pc4"},   pc_plus4_o,  pc + 32'd4);
    chk({tag, ".cnt"},   {29'd0, ras_count_o}, {29'd0, cnt});
    chk({tag, ".ovf"},   {31'd0, ras_ovf_o},   {31'd0, ovf});
    chk({tag, ".unf"},   {31'd0, ras_unf_o},   {31'd0, unf});
    chk({tag, ".mis"},   {31'd0, misalign_o},  {31'd0, mis});
  endtask

  task automatic step(input logic rst, input logic rdy, input logic [2:0] m,
                      input logic tk, input logic [31:0] bo, input logic [25:0] ji,
                      input logic [31:0] jr);
    Reset   = rst;
    ready_i = rdy;
    mode_i  = m;
    taken_i = tk;
    boff_i  = bo;
    jidx_i  = ji;
    jreg_i  = jr;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [2:0] m, input logic [25:0] ji, input logic [31:0] jr);
    step(1'b0, 1'b1, m, 1'b0, 32'd0, ji, jr);
  endtask

  initial begin
    Reset = 1'b1; ready_i = 1'b0; mode_i = M_SEQ; taken_i = 1'b0;
    boff_i = '0; jidx_i = '0; jreg_i = '0;

    // Reset and sequential fetch
    step(1'b1, 1'b1, M_SEQ, 1'b0, 32'd0, 26'd0, 32'd0);
    step(1'b1, 1'b1, M_SEQ, 1'b0, 32'd0, 26'd0, 32'd0);
    expect_state("reset", 32'h100, 3'd0, 1'b0, 1'b0, 1'b0);
    go(M_SEQ, 26'd0, 32'd0);  expect_state("seq1", 32'h104, 3'd0, 1'b0, 1'b0, 1'b0);
    go(M_SEQ, 26'd0, 32'd0);  expect_state("seq2", 32'h108, 3'd0, 1'b0, 1'b0, 1'b0);
    go(M_SEQ, 26'd0, 32'd0);  expect_state("seq3", 32'h10C, 3'd0, 1'b0, 1'b0, 1'b0);
    go(3'd7, 26'd0, 32'd0);   expect_state("rsvd7", 32'h110, 3'd0, 1'b0, 1'b0, 1'b0);

    // Branch taken / not taken from 0x200
    go(M_JREG, 26'd0, 32'h200); chk("br.setup", pc_o, 32'h200);
    step(1'b0, 1'b1, M_BR, 1'b1, 32'hFFFF_FFF0, 26'd0, 32'd0);
    expect_state("br.taken", 32'h1F4, 3'd0, 1'b0, 1'b0, 1'b0);
    go(M_JREG, 26'd0, 32'h200);
    step(1'b0, 1'b1, M_BR, 1'b0, 32'hFFFF_FFF0, 26'd0, 32'd0);
    expect_state("br.nt", 32'h204, 3'd0, 1'b0, 1'b0, 1'b0);

    // Jump keeps the upper region; JREG stalls then lands with misalign
    go(M_JREG, 26'd0, 32'hA000_0000); chk("jmp.setup", pc_o, 32'hA000_0000);
    go(M_JMP, 26'h40, 32'd0);
    expect_state("jmp", 32'hA000_0100, 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, M_JREG, 1'b0, 32'd0, 26'd0, 32'h1235);
    expect_state("stall1", 32'hA000_0100, 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, M_JREG, 1'b0, 32'd0, 26'd0, 32'h1235);
    expect_state("stall2", 32'hA000_0100, 3'd0, 1'b0, 1'b0, 1'b0);
    go(M_JREG, 26'd0, 32'h1235);
    expect_state("jreg", 32'h1234, 3'd0, 1'b0, 1'b0, 1'b1);
    go(M_SEQ, 26'd0, 32'd0);
    expect_state("jreg.after", 32'h1238, 3'd0, 1'b0, 1'b0, 1'b0);

    // Nested calls and returns
    go(M_JREG, 26'd0, 32'h10);
    go(M_CALL, 26'h8, 32'd0);   expect_state("call1", 32'h20, 3'd1, 1'b0, 1'b0, 1'b0);
    go(M_CALL, 26'hC, 32'd0);   expect_state("call2", 32'h30, 3'd2, 1'b0, 1'b0, 1'b0);
    go(M_CALL, 26'h40, 32'd0);  expect_state("call3", 32'h100, 3'd3, 1'b0, 1'b0, 1'b0);
    go(M_RET, 26'd0, 32'd0);    expect_state("ret1", 32'h34, 3'd2, 1'b0, 1'b0, 1'b0);
    go(M_RET, 26'd0, 32'd0);    expect_state("ret2", 32'h24, 3'd1, 1'b0, 1'b0, 1'b0);
    go(M_RET, 26'd0, 32'd0);    expect_state("ret3", 32'h14, 3'd0, 1'b0, 1'b0, 1'b0);

    // Overflow: 5 calls, oldest (0x18) is lost
    go(M_CALL, 26'h400, 32'd0); expect_state("ovc1", 32'h1000, 3'd1, 1'b0, 1'b0, 1'b0);
    go(M_CALL, 26'h440, 32'd0); expect_state("ovc2", 32'h1100, 3'd2, 1'b0, 1'b0, 1'b0);
    go(M_CALL, 26'h480, 32'd0); expect_state("ovc3", 32'h1200, 3'd3, 1'b0, 1'b0, 1'b0);
    go(M_CALL, 26'h4C0, 32'd0); expect_state("ovc4", 32'h1300, 3'd4, 1'b0, 1'b0, 1'b0);
    go(M_CALL, 26'h500, 32'd0); expect_state("ovc5", 32'h1400, 3'd4, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, M_CALL, 1'b0, 32'd0, 26'h600, 32'd0);
    expect_state("ov.stall", 32'h1400, 3'd4, 1'b0, 1'b0, 1'b0);
    go(M_RET, 26'd0, 32'd0);    expect_state("ovr1", 32'h1304, 3'd3, 1'b0, 1'b0, 1'b0);
    go(M_RET, 26'd0, 32'd0);    expect_state("ovr2", 32'h1204, 3'd2, 1'b0, 1'b0, 1'b0);
    go(M_RET, 26'd0, 32'd0);    expect_state("ovr3", 32'h1104, 3'd1, 1'b0, 1'b0, 1'b0);
    go(M_RET, 26'd0, 32'd0);    expect_state("ovr4", 32'h1004, 3'd0, 1'b0, 1'b0, 1'b0);
    go(M_RET, 26'd0, 32'd0);    expect_state("unf", 32'h1008, 3'd0, 1'b0, 1'b1, 1'b0);
    go(M_SEQ, 26'd0, 32'd0);    expect_state("unf.after", 32'h100C, 3'd0, 1'b0, 1'b0, 1'b0);

    // Reset in the same cycle as an advancing RET
    go(M_CALL, 26'h800, 32'd0); expect_state("rc1", 32'h2000, 3'd1, 1'b0, 1'b0, 1'b0);
    go(M_CALL, 26'h840, 32'd0); expect_state("rc2", 32'h2100, 3'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, M_RET, 1'b0, 32'd0, 26'd0, 32'd0);
    expect_state("rst.mid", 32'h100, 3'd0, 1'b0, 1'b0, 1'b0);
    go(M_RET, 26'd0, 32'd0);    expect_state("rst.unf", 32'h104, 3'd0, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Registered program-counter unit for the single-issue core. It replaces the combinational next-PC/branch/jump adder pair with one sequenced block. The block holds the PC and selects the next PC from six modes: sequential, branch-relative, absolute jump, jump-register, call and return. Calls and returns use an internal parametrised return-address stack (RAS), and the PC advances only when fetch accepts it.

## Interface
- `XLEN`, 32: PC and address width (≥ 8, multiple of 8).
- `JIDX_W`, 26: width of the absolute jump index field.
- `RAS_DEPTH`, 4: RAS entries (power of two, ≥ 2).
- `RESET_VECTOR`, 0: PC value loaded on reset (word aligned).
- `clk` in 1: rising-edge clock.
- `Reset` in 1: synchronous, active-high reset.
- `ready_i` in 1: fetch accepts `pc_o` this cycle (advance enable).
- `mode_i` in 3: next-PC mode, encodings in package.
- `taken_i` in 1: branch resolved taken (BRANCH mode only).
- `boff_i` in XLEN: signed byte offset for BRANCH, already shifted, relative to `pc_plus4_o`.
- `jidx_i` in JIDX_W: word index for JUMP/CALL.
- `jreg_i` in XLEN: register target for JREG.
- `pc_o` out XLEN: current PC.
- `pc_plus4_o` out XLEN: `pc_o + 4`, combinational from `pc_o`.
- `ras_count_o` out clog2(RAS_DEPTH)+1: valid RAS entries.
- `ras_ovf_o` out 1: one-cycle pulse, push onto full RAS.
- `ras_unf_o` out 1: one-cycle pulse, pop from empty RAS.
- `misalign_o` out 1: one-cycle pulse, JREG target had nonzero bits [1:0].

## Operation
- All updates occur when `advance = ready_i & ~Reset`. When `ready_i` = 0, the PC, RAS and counters hold, and the mode inputs are ignored.
- SEQ (0): next PC = `pc_plus4_o`.
- BRANCH (1): next PC = `pc_plus4_o + boff_i` if `taken_i`, else `pc_plus4_o`. Addition is XLEN-bit modulo with no overflow detection.
- JUMP (2): next PC = {`pc_plus4_o`[XLEN-1:JIDX_W+2], `jidx_i`, 2'b00}. When JIDX_W+2 ≥ XLEN, the upper field is empty and the index is truncated to XLEN-2 bits.
- JREG (3): next PC = {`jreg_i`[XLEN-1:2], 2'b00}. `misalign_o` pulses if `jreg_i`[1:0] ≠ 0.
- CALL (4): target as JUMP, and `pc_plus4_o` is pushed onto the RAS.
- RET (5): next PC = RAS top, which is popped. If the RAS is empty, next PC = `pc_plus4_o` and `ras_unf_o` pulses.
- Modes 6 and 7 are reserved and behave as SEQ.
- RAS is a circular buffer with a top pointer and a count.
  - Push when full overwrites the oldest entry. Count stays at RAS_DEPTH and `ras_ovf_o` pulses.
  - Count never underflows below 0.
- At most one RAS operation happens per cycle, so push and pop cannot collide.
- Reset, at any time including mid-stall, does the following:
  - `pc_o` = RESET_VECTOR.
  - RAS count and pointer = 0. Entry contents are don't-care.
  - All pulse outputs = 0.
- Reset dominates `ready_i` and every mode.

## Timing
- Single-cycle latency: mode applied in cycle n with `ready_i` = 1 appears on `pc_o` in cycle n+1.
- `pc_o`, `ras_count_o` and the pulse outputs are registered. `pc_plus4_o` is combinational from `pc_o` only, with no input-to-output combinational path.
- The RET target comes from the RAS state before this cycle's update. CALL-then-RET in consecutive advancing cycles returns the address pushed in the first cycle.
- The pulses are asserted for exactly the one cycle following the advancing cycle that caused them, and are 0 in every non-advancing cycle.
- The first cycle after Reset deasserts presents RESET_VECTOR on `pc_o`.

## Structure
- Package `pc_seq_pkg`:
  - mode localparams: `PCM_SEQ`, `PCM_BRANCH`, `PCM_JUMP`, `PCM_JREG`, `PCM_CALL`, `PCM_RET`;
  - the mode type (3 bits);
  - the default XLEN.
- Sub-module `ras_stack`:
  - parameters: XLEN, DEPTH;
  - ports: `push`, `pop`, `din`, `top`, `count`, `ovf`, `unf`.
  - Same clock and reset as the parent.
- Top-level `pc_sequencer` contains the mode mux, the adders and the PC register.

## Test plan
- Reset and sequence: Reset for 2 cycles, then SEQ with `ready_i` = 1 for 3 cycles, with RESET_VECTOR = 0x0000_0100. Required `pc_o` = 0x100, 0x104, 0x108, 0x10C.
- Branch: PC = 0x200, BRANCH, `boff_i` = 0xFFFF_FFF0. With `taken_i` = 1, next PC = 0x1F4. With `taken_i` = 0, next PC = 0x204.
- Jump, JREG and stall: PC = 0xA000_0000, JUMP with `jidx_i` = 0x0000_040 gives 0xA000_0100. Next, JREG with `jreg_i` = 0x1235 while `ready_i` = 0 for 2 cycles: PC holds. Then `ready_i` = 1 gives PC 0x1234 and a `misalign_o` pulse.
- RAS nesting: with RAS_DEPTH = 4, perform CALLs from PC 0x10, 0x20, 0x30, then 3 RETs. Required return targets: 0x34, 0x24, 0x14. `ras_count_o` goes 3 → 0 with no pulses.
- RAS boundaries:
  - 5 CALLs: `ras_ovf_o` pulses on the 5th and the count stays at 4. The following 4 RETs return the last 4 pushed addresses.
  - A 5th RET: `ras_unf_o` pulses and the next PC is `pc_plus4_o`.
- Reset mid-operation: assert Reset after 2 CALLs, in the same cycle as a RET with `ready_i` = 1. Required: `pc_o` = RESET_VECTOR, `ras_count_o` = 0, no pulses. A subsequent RET pulses `ras_unf_o`.
